// File: rtl/image_stream_dram_packer.sv
// rtl/image_stream_dram_packer.sv - pixel stream to DRAM word packer with single-beat write issue
//
// Purpose: packs LANES = DRAM_DATA_WIDTH/PIXEL_WIDTH pixels into one DRAM word
// and issues one single-beat write per word at consecutive addresses from a
// per-frame base. A pack buffer and a hold buffer let the next word fill while
// the previous one is in flight.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn         clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast  pixel stream in
//   frame_base_addr                   frame byte base, sampled at first issue of a frame
//   dram_write_addr/len/en/data       write request to the controller (len always 0)
//   dram_write_busy                   controller busy, rises the cycle after en
//   frame_done                        pulse when the last word of a frame is acknowledged
//   beats_written                     words acknowledged in the current frame
//   overflow_err                      sticky: beat index wrapped without tlast
module image_stream_dram_packer #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int PIXEL_WIDTH     = 32,
  parameter int BEAT_CNT_WIDTH  = 24
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_aresetn,
  input  logic [PIXEL_WIDTH-1:0]     s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [AXI_ADDR_WIDTH-1:0]  frame_base_addr,
  output logic [AXI_ADDR_WIDTH-1:0]  dram_write_addr,
  output logic [7:0]                 dram_write_len,
  output logic                       dram_write_en,
  output logic [DRAM_DATA_WIDTH-1:0] dram_write_data,
  input  logic                       dram_write_busy,
  output logic                       frame_done,
  output logic [BEAT_CNT_WIDTH-1:0]  beats_written,
  output logic                       overflow_err
);

  localparam int LANES          = DRAM_DATA_WIDTH / PIXEL_WIDTH;
  localparam int BYTES_PER_BEAT = DRAM_DATA_WIDTH / 8;
  localparam int LANE_W         = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_HI, W_WAIT_LO} w_state_e;

  // Pack stage
  logic [DRAM_DATA_WIDTH-1:0] pack_data_q;
  logic [LANE_W-1:0]          pack_cnt_q;
  logic                       pack_done_q, pack_done_d, pack_last_q, tready_q;
  // Hold stage
  logic [DRAM_DATA_WIDTH-1:0] hold_data_q;
  logic                       hold_valid_q, hold_last_q;
  // Write FSM
  w_state_e                   w_state_q;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q, base_q, issue_base, issue_addr;
  logic [DRAM_DATA_WIDTH-1:0] data_q;
  logic                       en_q, frame_done_q, overflow_q, cur_last_q;
  logic [BEAT_CNT_WIDTH-1:0]  beat_idx_q, beat_idx_inc, beats_q;

  logic pix_acc, word_end, hold_free, move;

  assign pix_acc   = s_axis_tvalid && tready_q;
  // tlast on the top lane completes a single word, never two.
  assign word_end  = pix_acc && ((pack_cnt_q == LANE_W'(LANES - 1)) || s_axis_tlast);
  // Hold is freed in the same cycle the FSM issues from it.
  assign hold_free = (w_state_q == W_IDLE) && hold_valid_q && !dram_write_busy;
  assign move      = pack_done_q && (!hold_valid_q || hold_free);
  // tready_q mirrors !pack_done_q, so move and word_end never coincide.
  assign pack_done_d = move ? 1'b0 : (pack_done_q || word_end);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      pack_data_q <= '0;
      pack_cnt_q  <= '0;
      pack_done_q <= 1'b0;
      pack_last_q <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      pack_done_q <= pack_done_d;
      tready_q    <= !pack_done_d;
      if (move) begin
        // Clearing on handoff leaves unused upper lanes zero for short words.
        pack_data_q <= '0;
      end else if (pix_acc) begin
        pack_data_q[int'(pack_cnt_q)*PIXEL_WIDTH +: PIXEL_WIDTH] <= s_axis_tdata;
        pack_cnt_q  <= word_end ? '0 : pack_cnt_q + LANE_W'(1);
        pack_last_q <= s_axis_tlast;
      end
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
    end else if (move) begin
      hold_data_q  <= pack_data_q;
      hold_last_q  <= pack_last_q;
      hold_valid_q <= 1'b1;
    end else if (hold_free) begin
      hold_valid_q <= 1'b0;
    end
  end

  // The first beat of a frame takes the live base; later beats reuse the latched one.
  always_comb begin
    issue_base   = (beat_idx_q == '0) ? frame_base_addr : base_q;
    issue_addr   = issue_base + AXI_ADDR_WIDTH'(beat_idx_q) * AXI_ADDR_WIDTH'(BYTES_PER_BEAT);
    beat_idx_inc = beat_idx_q + BEAT_CNT_WIDTH'(1);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      w_state_q    <= W_IDLE;
      en_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      base_q       <= '0;
      cur_last_q   <= 1'b0;
      beat_idx_q   <= '0;
      beats_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
      // beats_written shows the final count for the frame_done cycle, then clears.
      if (frame_done_q) beats_q <= '0;
      case (w_state_q)
        W_IDLE: begin
          if (hold_valid_q && !dram_write_busy) begin
            en_q       <= 1'b1;
            data_q     <= hold_data_q;
            addr_q     <= issue_addr;
            base_q     <= issue_base;
            cur_last_q <= hold_last_q;
            w_state_q  <= W_WAIT_HI;
          end
        end
        W_WAIT_HI: begin
          if (dram_write_busy) w_state_q <= W_WAIT_LO;
        end
        W_WAIT_LO: begin
          if (!dram_write_busy) begin
            beats_q <= beats_q + BEAT_CNT_WIDTH'(1);
            if (cur_last_q) begin
              frame_done_q <= 1'b1;
              beat_idx_q   <= '0;
            end else begin
              beat_idx_q <= beat_idx_inc;
              // Wrapping re-samples frame_base_addr on the next issue.
              if (beat_idx_inc == '0) overflow_q <= 1'b1;
            end
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign s_axis_tready   = tready_q;
  assign dram_write_addr = addr_q;
  assign dram_write_len  = 8'd0;
  assign dram_write_en   = en_q;
  assign dram_write_data = data_q;
  assign frame_done      = frame_done_q;
  assign beats_written   = beats_q;
  assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_image_stream_dram_packer.sv
// tb/tb_image_stream_dram_packer.sv - self-checking bench for image_stream_dram_packer
`timescale 1ns/1ps
module tb_image_stream_dram_packer;
  localparam int AW = 32, DW = 512, PW = 32, LANES = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // DUT A: default parameters
  logic [PW-1:0] tdata_a = '0;
  logic tvalid_a = 1'b0, tlast_a = 1'b0, tready_a;
  logic [AW-1:0] base_a = '0, addr_a;
  logic [7:0] len_a;
  logic en_a, fd_a, ovf_a, busy_a = 1'b0;
  logic [DW-1:0] data_a;
  logic [23:0] bw_a;

  // DUT B: 2-bit beat counter for the wrap case
  logic [PW-1:0] tdata_b = '0;
  logic tvalid_b = 1'b0, tlast_b = 1'b0, tready_b;
  logic [AW-1:0] base_b = '0, addr_b;
  logic [7:0] len_b;
  logic en_b, fd_b, ovf_b, busy_b = 1'b0;
  logic [DW-1:0] data_b;
  logic [1:0] bw_b;

  image_stream_dram_packer dut_a (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a), .s_axis_tlast(tlast_a),
    .frame_base_addr(base_a), .dram_write_addr(addr_a), .dram_write_len(len_a), .dram_write_en(en_a),
    .dram_write_data(data_a), .dram_write_busy(busy_a), .frame_done(fd_a), .beats_written(bw_a),
    .overflow_err(ovf_a));

  image_stream_dram_packer #(.BEAT_CNT_WIDTH(2)) dut_b (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b), .s_axis_tlast(tlast_b),
    .frame_base_addr(base_b), .dram_write_addr(addr_b), .dram_write_len(len_b), .dram_write_en(en_b),
    .dram_write_data(data_b), .dram_write_busy(busy_b), .frame_done(fd_b), .beats_written(bw_b),
    .overflow_err(ovf_b));

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Controller model + write monitor for DUT A
  int busy_len_a = 3, bcnt_a = 0, fd_cnt_a = 0;
  logic prev_en_a = 1'b0;
  logic [23:0] bw_max_a = '0;
  logic [AW-1:0] wr_addr_a[$];
  logic [DW-1:0] wr_data_a[$];

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bcnt_a = 0; busy_a = 1'b0; prev_en_a = 1'b0;
    end else begin
      busy_a = (bcnt_a > 0);
      if (bcnt_a > 0) bcnt_a--;
      if (en_a) begin
        chk("en_gap_a", {511'b0, prev_en_a}, '0);
        chk("len_a", {504'b0, len_a}, '0);
        wr_addr_a.push_back(addr_a);
        wr_data_a.push_back(data_a);
        bcnt_a = busy_len_a;
      end
      if (fd_a) fd_cnt_a++;
      if (bw_a > bw_max_a) bw_max_a = bw_a;
      prev_en_a = en_a;
    end
  end

  // Controller model + write monitor for DUT B
  int bcnt_b = 0, fd_cnt_b = 0;
  logic [AW-1:0] wr_addr_b[$];
  logic wr_ovf_b[$];
  logic [PW-1:0] wr_lane0_b[$];

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bcnt_b = 0; busy_b = 1'b0;
    end else begin
      busy_b = (bcnt_b > 0);
      if (bcnt_b > 0) bcnt_b--;
      if (en_b) begin
        chk("len_b", {504'b0, len_b}, '0);
        wr_addr_b.push_back(addr_b);
        wr_ovf_b.push_back(ovf_b);
        wr_lane0_b.push_back(data_b[PW-1:0]);
        bcnt_b = 2;
      end
      if (fd_b) fd_cnt_b++;
    end
  end

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Pushes start and end on a negedge; tready is sampled there, before the edge that uses it.
  task automatic push_a(input logic [PW-1:0] v, input logic last);
    int n = 0;
    tdata_a = v; tvalid_a = 1'b1; tlast_a = last;
    while (!tready_a && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      chk("tready_timeout_a", '0, 1);
      finish_now();
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic push_b(input logic [PW-1:0] v, input logic last);
    int n = 0;
    tdata_b = v; tvalid_b = 1'b1; tlast_b = last;
    while (!tready_b && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      chk("tready_timeout_b", '0, 1);
      finish_now();
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_fd_a(input int target, input string name);
    int n = 0;
    while (fd_cnt_a < target && n < 6000) begin @(negedge clk); n++; end
    chk(name, {511'b0, fd_cnt_a >= target}, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tready"}, {511'b0, tready_a}, '0);
    chk({tag, "_en"}, {511'b0, en_a}, '0);
    chk({tag, "_addr"}, {480'b0, addr_a}, '0);
    chk({tag, "_data"}, data_a, '0);
    chk({tag, "_len"}, {504'b0, len_a}, '0);
    chk({tag, "_frame_done"}, {511'b0, fd_a}, '0);
    chk({tag, "_beats"}, {488'b0, bw_a}, '0);
    chk({tag, "_ovf"}, {511'b0, ovf_a}, '0);
  endtask

  function automatic logic [DW-1:0] exp_word(input int npix, input logic [PW-1:0] start, input int w);
    logic [DW-1:0] r = '0;
    for (int k = 0; k < LANES; k++)
      if (w * LANES + k < npix) r[k*PW +: PW] = start + PW'(w * LANES + k);
    return r;
  endfunction

  typedef struct {
    int         npix;
    logic [31:0] start;
    logic [31:0] base;
    int         busy;
    int         nwords;
    logic [31:0] last_addr;
  } vec_t;
  vec_t vecs[6];

  task automatic run_frame(input vec_t v, input string tag);
    int f0, nw;
    base_a = v.base; busy_len_a = v.busy; bw_max_a = '0;
    wr_addr_a.delete(); wr_data_a.delete();
    f0 = fd_cnt_a;
    for (int i = 0; i < v.npix; i++) push_a(v.start + PW'(i), i == v.npix - 1);
    tvalid_a = 1'b0; tlast_a = 1'b0;
    wait_fd_a(f0 + 1, {tag, "_frame_done_seen"});
    repeat (2) @(negedge clk);
    nw = wr_addr_a.size();
    chk({tag, "_nwords"}, DW'(nw), DW'(v.nwords));
    for (int i = 0; i < nw && i < v.nwords; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {480'b0, wr_addr_a[i]}, {480'b0, v.base + AW'(i * 64)});
      chk($sformatf("%s_data%0d", tag, i), wr_data_a[i], exp_word(v.npix, v.start, i));
    end
    if (nw > 0) chk({tag, "_last_addr"}, {480'b0, wr_addr_a[nw-1]}, {480'b0, v.last_addr});
    chk({tag, "_frame_done_count"}, DW'(fd_cnt_a - f0), DW'(1));
    chk({tag, "_beats_peak"}, {488'b0, bw_max_a}, DW'(v.nwords));
    chk({tag, "_beats_cleared"}, {488'b0, bw_a}, '0);
  endtask

  initial begin
    int n;
    vecs[0] = '{16,   32'h0,      32'h1000_0000, 3,  1,  32'h1000_0000};
    vecs[1] = '{40,   32'h100,    32'h0,         4,  3,  32'h80};
    vecs[2] = '{1,    32'hABCD,   32'h1000,      2,  1,  32'h1000};
    vecs[3] = '{17,   32'h200,    32'h2000,      1,  2,  32'h2040};
    vecs[4] = '{32,   32'h300,    32'hFFFF_FFC0, 2,  2,  32'h0};
    vecs[5] = '{1024, 32'h1_0000, 32'h4000_0000, 10, 64, 32'h4000_0FC0};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", {511'b0, tready_a}, 1);

    foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back frames, base switched after the first frame's issue
    base_a = 32'h1000; busy_len_a = 3;
    wr_addr_a.delete(); wr_data_a.delete();
    n = fd_cnt_a;
    fork
      begin
        for (int i = 0; i < 16; i++) push_a(32'h500 + i, i == 15);
        for (int i = 0; i < 16; i++) push_a(32'h600 + i, i == 15);
        tvalid_a = 1'b0; tlast_a = 1'b0;
      end
      begin
        int c = 0;
        while (wr_addr_a.size() < 1 && c < 2000) begin @(negedge clk); c++; end
        base_a = 32'h2000;
      end
    join
    wait_fd_a(n + 2, "b2b_frames_done");
    chk("b2b_nwords", DW'(wr_addr_a.size()), DW'(2));
    if (wr_addr_a.size() >= 2) begin
      chk("b2b_addr0", {480'b0, wr_addr_a[0]}, {480'b0, 32'h1000});
      chk("b2b_addr1", {480'b0, wr_addr_a[1]}, {480'b0, 32'h2000});
      chk("b2b_data1", wr_data_a[1], exp_word(16, 32'h600, 0));
    end

    // Reset in W_WAIT_LO with a half-packed word
    base_a = 32'h7000; busy_len_a = 20;
    wr_addr_a.delete(); wr_data_a.delete();
    for (int i = 0; i < 16; i++) push_a(32'h10 + i, 1'b0);
    for (int i = 0; i < 8; i++) push_a(32'h40 + i, 1'b0);
    tvalid_a = 1'b0;
    n = 0;
    while (!(wr_addr_a.size() >= 1 && busy_a) && n < 200) begin @(negedge clk); n++; end
    chk("midreset_issue_seen", DW'(wr_addr_a.size()), DW'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_midreset", {511'b0, tready_a}, 1);
    run_frame('{16, 32'h900, 32'h3000, 3, 1, 32'h3000}, "post_reset");

    // Beat counter wrap without tlast on the 2-bit instance
    base_b = 32'h500;
    for (int i = 0; i < 80; i++) push_b(PW'(i), 1'b0);
    tvalid_b = 1'b0;
    n = 0;
    while (wr_addr_b.size() < 5 && n < 500) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("wrap_nwords", DW'(wr_addr_b.size()), DW'(5));
    if (wr_addr_b.size() >= 5) begin
      chk("wrap_addr0", {480'b0, wr_addr_b[0]}, {480'b0, 32'h500});
      chk("wrap_addr3", {480'b0, wr_addr_b[3]}, {480'b0, 32'h5C0});
      chk("wrap_addr4", {480'b0, wr_addr_b[4]}, {480'b0, 32'h500});
      chk("wrap_ovf_at4", {511'b0, wr_ovf_b[3]}, '0);
      chk("wrap_ovf_at5", {511'b0, wr_ovf_b[4]}, 1);
      chk("wrap_lane0_5th", {480'b0, wr_lane0_b[4]}, DW'(64));
    end
    chk("wrap_ovf_sticky", {511'b0, ovf_b}, 1);
    chk("wrap_beats", {510'b0, bw_b}, DW'(1));
    chk("wrap_no_frame_done", DW'(fd_cnt_b), '0);

    finish_now();
  end

endmodule
